// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB snoop and issue signals between the rename/dispatch stage,
// the CDB and the integer ALU reservation station.
interface alu_reservation_station_if #(
    parameter int WIDTH   = 31,
    parameter int C_WIDTH = 3,
    parameter int T_WIDTH = 3
);
    logic               flush;
    logic               dispValid;
    logic [C_WIDTH:0]   dispControl;
    logic [WIDTH:0]     dispSrc1;
    logic [WIDTH:0]     dispSrc2;
    logic [T_WIDTH:0]   dispTag1;
    logic [T_WIDTH:0]   dispTag2;
    logic               dispRdy1;
    logic               dispRdy2;
    logic [T_WIDTH:0]   dispRob;
    logic               rsFull;
    logic               cdbValid;
    logic [T_WIDTH:0]   cdbTag;
    logic [WIDTH:0]     cdbResult;
    logic               aluStall;
    logic               issueValid;
    logic [WIDTH:0]     src1;
    logic [WIDTH:0]     src2;
    logic [C_WIDTH:0]   ALUControl;
    logic [T_WIDTH:0]   issueRob;

    modport master (
        output flush, dispValid, dispControl, dispSrc1, dispSrc2, dispTag1, dispTag2,
               dispRdy1, dispRdy2, dispRob, cdbValid, cdbTag, cdbResult, aluStall,
        input  rsFull, issueValid, src1, src2, ALUControl, issueRob
    );

    modport slave (
        input  flush, dispValid, dispControl, dispSrc1, dispSrc2, dispTag1, dispTag2,
               dispRdy1, dispRdy2, dispRob, cdbValid, cdbTag, cdbResult, aluStall,
        output rsFull, issueValid, src1, src2, ALUControl, issueRob
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Integer ALU reservation station: holds micro-ops until both operands are
// captured (at dispatch or from the CDB), then issues the lowest ready entry.
module alu_reservation_station #(
    parameter int WIDTH   = 31,
    parameter int C_WIDTH = 3,
    parameter int T_WIDTH = 3,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    alu_reservation_station_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  rdy1_q, rdy1_d;
    logic [DEPTH-1:0]  rdy2_q, rdy2_d;
    logic [C_WIDTH:0]  ctrl_q [DEPTH];
    logic [C_WIDTH:0]  ctrl_d [DEPTH];
    logic [WIDTH:0]    val1_q [DEPTH];
    logic [WIDTH:0]    val1_d [DEPTH];
    logic [WIDTH:0]    val2_q [DEPTH];
    logic [WIDTH:0]    val2_d [DEPTH];
    logic [T_WIDTH:0]  tag1_q [DEPTH];
    logic [T_WIDTH:0]  tag1_d [DEPTH];
    logic [T_WIDTH:0]  tag2_q [DEPTH];
    logic [T_WIDTH:0]  tag2_d [DEPTH];
    logic [T_WIDTH:0]  rob_q  [DEPTH];
    logic [T_WIDTH:0]  rob_d  [DEPTH];

    logic              iss_valid_q, iss_valid_d;
    logic [WIDTH:0]    iss_src1_q, iss_src1_d;
    logic [WIDTH:0]    iss_src2_q, iss_src2_d;
    logic [C_WIDTH:0]  iss_ctrl_q, iss_ctrl_d;
    logic [T_WIDTH:0]  iss_rob_q, iss_rob_d;

    logic [DEPTH-1:0]  ready;
    logic              has_ready;
    logic [IDX_W-1:0]  sel;
    logic              has_free;
    logic [IDX_W-1:0]  free_idx;
    logic              rs_full;
    logic              fwd1;
    logic              fwd2;

    assign rs_full = &valid_q;

    always_comb begin
        valid_d     = valid_q;
        rdy1_d      = rdy1_q;
        rdy2_d      = rdy2_q;
        ctrl_d      = ctrl_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        tag1_d      = tag1_q;
        tag2_d      = tag2_q;
        rob_d       = rob_q;
        iss_valid_d = iss_valid_q;
        iss_src1_d  = iss_src1_q;
        iss_src2_d  = iss_src2_q;
        iss_ctrl_d  = iss_ctrl_q;
        iss_rob_d   = iss_rob_q;
        has_ready   = 1'b0;
        sel         = '0;
        has_free    = 1'b0;
        free_idx    = '0;
        fwd1        = 1'b0;
        fwd2        = 1'b0;

        // Select and allocation both look only at pre-edge state
        ready = valid_q & rdy1_q & rdy2_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ready[i] && !has_ready) begin
                has_ready = 1'b1;
                sel       = IDX_W'(i);
            end
            if (!valid_q[i] && !has_free) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.cdbValid && valid_q[i]) begin
                if (!rdy1_q[i] && (tag1_q[i] == bus.cdbTag)) begin
                    val1_d[i] = bus.cdbResult;
                    rdy1_d[i] = 1'b1;
                end
                if (!rdy2_q[i] && (tag2_q[i] == bus.cdbTag)) begin
                    val2_d[i] = bus.cdbResult;
                    rdy2_d[i] = 1'b1;
                end
            end
        end

        if (!bus.aluStall) begin
            if (has_ready) begin
                iss_valid_d    = 1'b1;
                iss_src1_d     = val1_q[sel];
                iss_src2_d     = val2_q[sel];
                iss_ctrl_d     = ctrl_q[sel];
                iss_rob_d      = rob_q[sel];
                valid_d[sel]   = 1'b0;
            end else begin
                iss_valid_d    = 1'b0;
                iss_ctrl_d     = '1;
            end
        end

        // The freed slot is never a valid_q entry, so it cannot collide with issue or wakeup
        if (bus.dispValid && !rs_full && !bus.flush && has_free) begin
            fwd1 = !bus.dispRdy1 && bus.cdbValid && (bus.dispTag1 == bus.cdbTag);
            fwd2 = !bus.dispRdy2 && bus.cdbValid && (bus.dispTag2 == bus.cdbTag);
            valid_d[free_idx] = 1'b1;
            ctrl_d[free_idx]  = bus.dispControl;
            val1_d[free_idx]  = fwd1 ? bus.cdbResult : bus.dispSrc1;
            val2_d[free_idx]  = fwd2 ? bus.cdbResult : bus.dispSrc2;
            rdy1_d[free_idx]  = bus.dispRdy1 | fwd1;
            rdy2_d[free_idx]  = bus.dispRdy2 | fwd2;
            tag1_d[free_idx]  = bus.dispTag1;
            tag2_d[free_idx]  = bus.dispTag2;
            rob_d[free_idx]   = bus.dispRob;
        end

        if (bus.flush) begin
            valid_d     = '0;
            iss_valid_d = 1'b0;
            iss_ctrl_d  = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                rob_q[i]  <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_src1_q  <= '0;
            iss_src2_q  <= '0;
            iss_ctrl_q  <= '1;
            iss_rob_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            rdy1_q      <= rdy1_d;
            rdy2_q      <= rdy2_d;
            ctrl_q      <= ctrl_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            rob_q       <= rob_d;
            iss_valid_q <= iss_valid_d;
            iss_src1_q  <= iss_src1_d;
            iss_src2_q  <= iss_src2_d;
            iss_ctrl_q  <= iss_ctrl_d;
            iss_rob_q   <= iss_rob_d;
        end
    end

    assign bus.rsFull     = rs_full;
    assign bus.issueValid = iss_valid_q;
    assign bus.src1       = iss_src1_q;
    assign bus.src2       = iss_src2_q;
    assign bus.ALUControl = iss_ctrl_q;
    assign bus.issueRob   = iss_rob_q;

    // Dispatching into a full station is an upstream protocol violation
    a_no_disp_when_full: assert property (
        @(posedge clk) disable iff (reset) !(bus.dispValid && rs_full)
    );
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: dispatch, wakeup, forwarding,
// priority/full, stall, flush and asynchronous reset.
module tb_alu_reservation_station;
    logic clk;
    logic reset;
    int   tests;
    int   failed;

    alu_reservation_station_if #(.WIDTH(31), .C_WIDTH(3), .T_WIDTH(3)) bus ();

    alu_reservation_station #(.WIDTH(31), .C_WIDTH(3), .T_WIDTH(3), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] c, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [3:0] t1, input logic [3:0] t2,
                        input logic r1, input logic r2, input logic [3:0] rob);
        bus.dispValid   = 1'b1;
        bus.dispControl = c;
        bus.dispSrc1    = s1;
        bus.dispSrc2    = s2;
        bus.dispTag1    = t1;
        bus.dispTag2    = t2;
        bus.dispRdy1    = r1;
        bus.dispRdy2    = r2;
        bus.dispRob     = rob;
    endtask

    task automatic idle();
        bus.dispValid = 1'b0;
        bus.cdbValid  = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic [3:0] c, input logic [31:0] s1,
                               input logic [31:0] s2, input logic [3:0] rob);
        check({tag, "_valid"}, 32'(bus.issueValid), 32'd1);
        check({tag, "_ctrl"}, 32'(bus.ALUControl), 32'(c));
        check({tag, "_src1"}, bus.src1, s1);
        check({tag, "_src2"}, bus.src2, s2);
        check({tag, "_rob"}, 32'(bus.issueRob), 32'(rob));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.issueValid), 32'd0);
        check({tag, "_ctrl"}, 32'(bus.ALUControl), 32'hF);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        bus.flush = 1'b0;
        bus.aluStall = 1'b0;
        bus.cdbTag = '0;
        bus.cdbResult = '0;
        disp(4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        idle();
        tick();
        tick();
        check_idle("reset");
        check("reset_src1", bus.src1, 32'h0);
        check("reset_src2", bus.src2, 32'h0);
        check("reset_rob", 32'(bus.issueRob), 32'h0);
        check("reset_full", 32'(bus.rsFull), 32'h0);
        reset = 1'b0;
        tick();

        // 1: ready dispatch issues one cycle later
        disp(4'h0, 32'd5, 32'd7, 4'h0, 4'h0, 1'b1, 1'b1, 4'd3);
        tick();
        idle();
        check_idle("t1_disp");
        tick();
        check_issue("t1_issue", 4'h0, 32'd5, 32'd7, 4'd3);
        tick();
        check_idle("t1_drain");

        // 2: CDB wakeup, eligible the cycle after capture
        disp(4'h8, 32'hDEAD, 32'd2, 4'd9, 4'd0, 1'b0, 1'b1, 4'd5);
        tick();
        idle();
        tick();
        check_idle("t2_wait");
        bus.cdbValid  = 1'b1;
        bus.cdbTag    = 4'd9;
        bus.cdbResult = 32'd20;
        tick();
        idle();
        check_idle("t2_woken");
        tick();
        check_issue("t2_issue", 4'h8, 32'd20, 32'd2, 4'd5);
        tick();
        check_idle("t2_drain");

        // 3: forwarding on the dispatch cycle
        disp(4'h2, 32'd1, 32'h0, 4'd0, 4'd4, 1'b1, 1'b0, 4'd7);
        bus.cdbValid  = 1'b1;
        bus.cdbTag    = 4'd4;
        bus.cdbResult = 32'hFFFF_FFFF;
        tick();
        idle();
        tick();
        check_issue("t3_issue", 4'h2, 32'd1, 32'hFFFF_FFFF, 4'd7);
        tick();
        check_idle("t3_drain");

        // 4: fill, then broadcast; index-order issue
        for (int i = 0; i < 4; i++) begin
            disp(i[3:0], 32'h0, 32'(10 + i), 4'd1, 4'd0, 1'b0, 1'b1, i[3:0]);
            tick();
        end
        idle();
        check("t4_full", 32'(bus.rsFull), 32'd1);
        check_idle("t4_full_idle");
        bus.cdbValid  = 1'b1;
        bus.cdbTag    = 4'd1;
        bus.cdbResult = 32'd100;
        tick();
        idle();
        check("t4_full_woken", 32'(bus.rsFull), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_issue($sformatf("t4_issue%0d", i), i[3:0], 32'd100, 32'(10 + i), i[3:0]);
            check($sformatf("t4_full%0d", i), 32'(bus.rsFull), 32'd0);
        end
        tick();
        check_idle("t4_drain");

        // 5: stall holds issue registers and the waiting entry
        disp(4'h1, 32'd11, 32'd12, 4'd0, 4'd0, 1'b1, 1'b1, 4'd8);
        tick();
        disp(4'h2, 32'd21, 32'd22, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9);
        tick();
        idle();
        check_issue("t5_first", 4'h1, 32'd11, 32'd12, 4'd8);
        bus.aluStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_issue($sformatf("t5_stall%0d", i), 4'h1, 32'd11, 32'd12, 4'd8);
        end
        bus.aluStall = 1'b0;
        tick();
        check_issue("t5_second", 4'h2, 32'd21, 32'd22, 4'd9);
        tick();
        check_idle("t5_drain");

        // 6a: flush with three waiting entries and a live issue (stalled)
        disp(4'h3, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd10);
        tick();
        disp(4'h4, 32'd3, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd11);
        tick();
        bus.aluStall = 1'b1;
        disp(4'h5, 32'd5, 32'd6, 4'd0, 4'd0, 1'b1, 1'b1, 4'd12);
        tick();
        disp(4'h6, 32'd7, 32'd8, 4'd0, 4'd0, 1'b1, 1'b1, 4'd13);
        tick();
        idle();
        check_issue("t6_pre", 4'h3, 32'd1, 32'd2, 4'd10);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.aluStall = 1'b0;
        check_idle("t6_flush");
        check("t6_flush_full", 32'(bus.rsFull), 32'd0);
        tick();
        check_idle("t6_after1");
        tick();
        check_idle("t6_after2");

        // 6b: asynchronous reset mid-cycle discards issue and station contents
        disp(4'h7, 32'd30, 32'd31, 4'd0, 4'd0, 1'b1, 1'b1, 4'd14);
        tick();
        disp(4'h9, 32'd40, 32'd41, 4'd0, 4'd0, 1'b1, 1'b1, 4'd15);
        tick();
        idle();
        check_issue("t6_live", 4'h7, 32'd30, 32'd31, 4'd14);
        #2;
        reset = 1'b1;
        #1;
        check_idle("t6_async");
        check("t6_async_src1", bus.src1, 32'h0);
        check("t6_async_src2", bus.src2, 32'h0);
        check("t6_async_rob", 32'(bus.issueRob), 32'h0);
        reset = 1'b0;
        tick();
        check_idle("t6_post1");
        tick();
        check_idle("t6_post2");
        check("t6_post_full", 32'(bus.rsFull), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
